// File: rtl/seq_div.sv
// ---------------------------------------------------------------------------
// seq_div -- multi-cycle radix-2 restoring divider (MIPS DIV / DIVU).
//
// One quotient bit is retired per clock. Signed operands are converted to
// magnitudes on entry, divided unsigned, and the result signs are applied in
// a final fix-up cycle. Results and flags are held until the next operation
// completes.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   start      in   1      operation request, sampled only while idle
//   is_signed  in   1      1 = DIV (two's complement), 0 = DIVU
//   a          in   WIDTH  dividend
//   b          in   WIDTH  divisor
//   busy       out  1      operation in flight
//   done       out  1      one-cycle pulse, results valid from this cycle
//   quotient   out  WIDTH  quotient (LO)
//   remainder  out  WIDTH  remainder (HI)
//   dz_flag    out  1      divisor was zero
//   of_flag    out  1      signed overflow (most-negative / -1)
// ---------------------------------------------------------------------------
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz_flag,
  output logic             of_flag
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q,   rem_d;    // partial remainder
  logic [WIDTH-1:0] dvd_q,   dvd_d;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q,   dvs_d;    // divisor magnitude
  logic [WIDTH-1:0] a_raw_q, a_raw_d;  // original dividend, returned on divide-by-zero
  logic             qneg_q,  qneg_d;
  logic             rneg_q,  rneg_d;
  logic             dz_q,    dz_d;
  logic             of_q,    of_d;

  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] remo_q,  remo_d;
  logic             dzf_q,   dzf_d;
  logic             off_q,   off_d;
  logic             done_q,  done_d;

  // Iteration datapath: shifted partial remainder and trial subtraction.
  // The extra top bit keeps the sign of the trial difference.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign shifted = {1'b0, rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvs_q};

  // The most-negative dividend negates to itself, which read as unsigned is
  // exactly 2^(WIDTH-1) -- the magnitude we want.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      a_raw_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      of_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dzf_q   <= 1'b0;
      off_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      a_raw_q <= a_raw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      of_q    <= of_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dzf_q   <= dzf_d;
      off_q   <= off_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    a_raw_d = a_raw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    of_d    = of_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dzf_d   = dzf_q;
    off_d   = off_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          count_d = '0;
          a_raw_d = a;
          qneg_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = is_signed && a[WIDTH-1];
          dz_d    = (b == '0);
          of_d    = is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
          state_d = (b == '0) ? S_FIX : S_CALC;
        end
      end

      S_CALC: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          // Restore: the shifted remainder is below the divisor, so it fits.
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (dz_q) begin
          quot_d = '1;
          remo_d = a_raw_q;
        end else begin
          quot_d = qneg_q ? -dvd_q : dvd_q;
          remo_d = rneg_q ? -rem_q : rem_q;
        end
        dzf_d   = dz_q;
        off_d   = of_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign dz_flag   = dzf_q;
  assign of_flag   = off_q;

endmodule
